// File: rtl/div_unit_pkg.sv
// Shared CPU definitions: ALU opcodes, divide-select encoding, divider FSM
// states and the default datapath width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_MUL  = 4'hA,
    ALU_DIV  = 4'hB,
    ALU_DIVU = 4'hC
  } alu_op_e;

  // Value of the divider's sign input selecting each flavour.
  localparam logic DIV_SEL_DIVU = 1'b0;
  localparam logic DIV_SEL_DIV  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only if it did not borrow.
import div_unit_pkg::*;

module div_step #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_i, dvd_bit_i};
  assign diff    = shifted - {2'b00, dvs_i};
  // The borrow out of the trial subtraction decides the quotient bit.
  assign q_bit_o = ~diff[WIDTH+1];
  assign rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_unit.sv
// Iterative WIDTH-cycle divider for DIV/DIVU; magnitudes are divided by
// div_step and signs are applied to the final quotient and remainder here.
import div_unit_pkg::*;

module div_unit #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next;
  logic             is_signed;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .dvd_bit_i(dvd_q[WIDTH-1]),
    .dvs_i    (dvs_q),
    .rem_o    (rem_next),
    .q_bit_o  (q_bit)
  );

  assign is_signed = (sign == DIV_SEL_DIV);
  // Dividend register doubles as the quotient: bits shift out MSB first,
  // quotient bits shift in at the LSB.
  assign quo_next  = {dvd_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          dvd_d   = magnitude(dividend, is_signed);
          dvs_d   = magnitude(divisor, is_signed);
          rem_d   = '0;
          cnt_d   = '0;
          negq_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = is_signed & dividend[WIDTH-1];
          dz_d    = (divisor == '0);
        end
      end
      ST_RUN: begin
        dvd_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          // Divide-by-zero yields all ones regardless of mode; the remainder
          // naturally comes back as the original dividend.
          q_d     = dz_q ? '1 : (negq_q ? -quo_next : quo_next);
          r_d     = negr_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against an arithmetic model.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sign = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] q, r;
  logic         busy, done;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sign    (sign),
    .dividend(dividend),
    .divisor (divisor),
    .q       (q),
    .r       (r),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truncating division done with 64-bit integer arithmetic.
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eq, output logic [W-1:0] er);
    longint sa, sb, qq, rr;
    if (b == 0) begin
      eq = '1;
      er = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      eq = qq[W-1:0];
      er = rr[W-1:0];
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  // Drives start for exactly one sampling edge; returns #1 after that edge.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    sign = s;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = 0;
    while (!done && n < W + 8) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic s, input logic [W-1:0] a,
                              input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    model(s, a, b, eq, er);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int n, bc;
    @(negedge clk);
    issue(s, a, b);
    wait_done(n, bc);
    chk({tag, "_lat"}, n, W);
    chk({tag, "_busy_cycles"}, bc, W);
    chk({tag, "_busy_at_done"}, busy, 0);
    check_result(tag, s, a, b);
  endtask

  logic [W-1:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

  initial begin
    int n, bc, seen_done;
    logic [W-1:0] a, b;
    logic s;

    #2;
    chk("reset_q", q, 0);
    chk("reset_r", r, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("u100_7", 1'b0, 100, 7);
    chk("u100_7_q_const", q, 14);
    chk("u100_7_r_const", r, 2);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);

    run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 2);
    chk("s_m7_2_q_const", q, 32'hFFFFFFFD);
    chk("s_m7_2_r_const", r, 32'hFFFFFFFF);
    run_op("s_7_m2", 1'b1, 7, 32'hFFFFFFFE);
    chk("s_7_m2_q_const", q, 32'hFFFFFFFD);
    chk("s_7_m2_r_const", r, 1);
    run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    chk("s_ovf_q_const", q, 32'h80000000);
    chk("s_ovf_r_const", r, 0);
    run_op("u_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF);
    chk("u_ovf_q_const", q, 0);
    chk("u_ovf_r_const", r, 32'h80000000);
    run_op("u_dz", 1'b0, 32'h1234, 0);
    chk("u_dz_q_const", q, 32'hFFFFFFFF);
    chk("u_dz_r_const", r, 32'h1234);
    run_op("s_dz", 1'b1, 32'h1234, 0);
    chk("s_dz_q_const", q, 32'hFFFFFFFF);
    chk("s_dz_r_const", r, 32'h1234);
    run_op("s_dz_neg", 1'b1, 32'hFFFFFF00, 0);

    // Start pulsed while busy must be ignored; start on done is accepted.
    @(negedge clk);
    issue(1'b0, 100, 7);
    repeat (4) @(posedge clk);
    #1;
    issue(1'b0, 50, 5);
    chk("hold_q_midrun", q, 32'hFFFFFFFF);
    chk("hold_r_midrun", r, 32'hFFFFFF00);
    wait_done(n, bc);
    chk("ignored_lat", n, W - 5);
    chk("ignored_q", q, 14);
    chk("ignored_r", r, 2);
    issue(1'b0, 50, 5);
    chk("ondone_busy", busy, 1);
    wait_done(n, bc);
    chk("ondone_lat", n, W);
    chk("ondone_q", q, 10);
    chk("ondone_r", r, 0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    issue(1'b0, 100, 7);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_q", q, 0);
    chk("abort_r", r, 0);
    seen_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
      if (i == 2) rst_n = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);
    run_op("after_reset_9_3", 1'b0, 9, 3);
    chk("after_reset_q_const", q, 3);
    chk("after_reset_r_const", r, 0);

    // Randomized operands with a bias toward boundary values.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
      case ($urandom_range(0, 3))
        0: b = specials[$urandom_range(0, 5)];
        1: b = W'($urandom_range(1, 300));
        default: b = W'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), s, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a division; sampled on rising edge of clk.
REQ-005 SHALL have port sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-007 SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-008 SHALL have port q  output  WIDTH  quotient (LO destination).
REQ-009 SHALL have port r  output  WIDTH  remainder (HI destination).
REQ-010 SHALL have port busy  output  1  division in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; q/r valid.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, RUN.
REQ-013 In IDLE, start=1 SHALL latch sign, operand magnitudes and operand signs, clear the iteration counter, and enter RUN.
REQ-014 In RUN, SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit per cycle, MSB first.
REQ-015 After exactly WIDTH RUN cycles SHALL return to IDLE, update q/r, and assert done for one cycle.
REQ-016 Latency: for start sampled at edge E0, busy SHALL be 1 after edges E0..E(WIDTH-1), and done=1 with busy=0 after edge E(WIDTH).
REQ-017 start while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-018 start in the same cycle done=1 (IDLE) SHALL be accepted.
REQ-019 q and r SHALL hold their last result until the next done; they are not updated while RUN is in progress.
REQ-020 Signed mode SHALL use truncating division: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield q=0x80000000, r=0 without error.
REQ-022 Divisor 0 SHALL still take the full WIDTH-cycle latency and yield q=all ones, r=dividend, in both modes.
REQ-023 Internal partial remainder SHALL be WIDTH+1 bits wide so the trial subtraction's borrow is its MSB.
REQ-024 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL not wrap during a run.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, q=0, r=0, busy=0, done=0, counter=0, working registers=0.
REQ-026 Reset asserted mid-RUN SHALL abort the division with no done pulse.
REQ-027 The first start after rst_n rises SHALL be accepted normally.

Structure
REQ-028 The FSM state encoding and the WIDTH default SHALL live in the CPU's shared package, alongside the ALU opcode constants.
REQ-029 The DIV/DIVU select encoding SHALL be defined in that package.
REQ-030 One sub-module, div_step, SHALL be instantiated: a combinational single-iteration shift/trial-subtract/restore step.
REQ-031 Sign pre-conditioning (absolute value) and post-correction (negation) SHALL be done in div_unit, not in div_step.

Verification
REQ-032 Unsigned 100/7 -> q=14, r=2, done exactly WIDTH edges after the start edge, busy high WIDTH cycles.
REQ-033 Signed 0xFFFFFFF9/2 (-7/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
REQ-034 0x80000000 / 0xFFFFFFFF: signed -> q=0x80000000, r=0; unsigned -> q=0, r=0x80000000.
REQ-035 Divisor 0, dividend 0x1234 -> q=0xFFFFFFFF, r=0x1234 in both modes.
REQ-036 Second start (50/5) pulsed mid-run of 100/7 -> ignored, result q=14, r=2; start (50/5) on the done cycle -> q=10, r=0.
REQ-037 rst_n low at RUN cycle 10 -> busy=0, q=0, r=0 immediately, no done pulse; next start 9/3 -> q=3, r=0.
